fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
Read-side consumer stage for the asynchronous FIFO, running entirely in the rclk domain. It drives the FIFO's r_en from the FIFO's empty flag and a credit count, and captures data_out after the FIFO's read latency. Captured words go into a small skid buffer and are presented downstream on a valid/ready stream. Downstream back-pressure never causes a read of an empty FIFO, and no word is lost or duplicated.

Parameters:
FIFO_WIDTH, 32, data word width; must match the FIFO.
SKID_DEPTH, 2, skid buffer entries; must be >= 1, and >= RD_LAT+1 for 1 word/cycle.
RD_LAT, 1, rclk cycles from a sampled r_en to valid data_out.
CNT_WIDTH, 16, width of the accepted-word counter.

Ports:
rclk  in  1  read clock
rrst_n  in  1  read-domain reset
fifo_empty  in  1  FIFO empty flag
fifo_data_out  in  FIFO_WIDTH  FIFO read data
fifo_r_en  out  1  FIFO read enable
flush  in  1  synchronous, active-high; discard buffered and in-flight data
m_valid  out  1  downstream data valid
m_data  out  FIFO_WIDTH  downstream data, head of skid buffer
m_ready  in  1  downstream ready
busy  out  1  high when state is FLUSH
rd_count  out  CNT_WIDTH  count of accepted downstream handshakes

Behaviour:
- Reset: rrst_n is synchronous, active-low.
  - While rrst_n=0 at a rising rclk edge: fifo_r_en=0, m_valid=0, m_data=0, rd_count=0, busy=0.
  - The in-flight shift register, buffer occupancy and read/write pointers all clear; state goes to STREAM.
  - Data returning from reads issued before reset is discarded.
- Read path:
  - inflight is an RD_LAT-deep shift register of issued-read markers.
  - At cycle t+RD_LAT after fifo_r_en=1 was sampled, fifo_data_out is written into the skid buffer.
- Issue rule (combinational fifo_r_en). Assert fifo_r_en only when all hold:
  - state == STREAM
  - !flush
  - !fifo_empty
  - occ + popcount(inflight) - (m_valid && m_ready) < SKID_DEPTH
- Reading an empty FIFO is forbidden: fifo_r_en=1 with fifo_empty=1 is a design error.
- Pop: the handshake m_valid && m_ready removes the head.
  - A push and a pop in the same cycle leave occ unchanged.
  - m_valid = (occ != 0).
  - m_data is registered and stable while m_valid && !m_ready.
- Ordering: strict FIFO order. The buffer pointers wrap modulo SKID_DEPTH.
- Width: occ is clog2(SKID_DEPTH+1) bits. rd_count increments by 1 per handshake and wraps 2^CNT_WIDTH-1 -> 0.
- State machine:
  - STREAM: normal operation.
  - STREAM -> FLUSH on flush=1. In that same cycle: occ:=0, m_valid:=0, fifo_r_en=0, and any pop is ignored.
  - FLUSH: fifo_r_en held 0, busy=1. Returning in-flight data is dropped.
  - FLUSH -> STREAM when inflight == 0 and flush == 0. The minimum FLUSH duration is one cycle.
  - flush held high keeps the block in FLUSH.
- rd_count is not cleared by flush.
- Throughput:
  - With SKID_DEPTH >= RD_LAT+1, the FIFO continuously non-empty and m_ready=1: m_valid stays 1 and one word is accepted per cycle.
  - First-word latency from fifo_empty falling is RD_LAT+1 cycles to m_valid.
- Boundaries:
  - Buffer full with m_ready=0: fifo_r_en=0 even if the FIFO is non-empty.
  - fifo_empty rising while reads are in flight: the in-flight words are still captured.
  - Reset during FLUSH returns to STREAM.

Decomposition:
- FIFO_pkg holds the shared items:
  - FIFO_WIDTH
  - the default RD_LAT
  - the typedef rd_state_e {STREAM, FLUSH}
- One sub-module: skid_buf. It is a parameterised SKID_DEPTH x FIFO_WIDTH circular buffer with push/pop, occ and head outputs, sharing rclk/rrst_n.
- The top level holds the issue logic, the inflight shift register, the FSM and rd_count.

Test Plan:
1. Reset: hold rrst_n=0 for 2 rclk with FIFO non-empty -> fifo_r_en=0, m_valid=0, m_data=0, rd_count=0. Release -> first fifo_r_en=1 on the next cycle.
2. Streaming: FIFO preloaded with 0x00000001..0x00000008, m_ready=1 -> m_data emits 1..8 on 8 consecutive cycles; rd_count=8; no fifo_r_en while fifo_empty=1.
3. Back-pressure: 4 words (0xA0..0xA3) queued, m_ready=0 for 6 cycles -> at most SKID_DEPTH=2 reads issued and m_data holds 0xA0 stable. Release -> 0xA0..0xA3 delivered in order, none lost or duplicated.
4. Flush with a read in flight: assert flush for 1 cycle right after a read issues -> m_valid=0 next cycle, busy=1 until inflight drains. The dropped word never appears; the next FIFO word 0xB5 is the first one delivered.
5. Empty boundary: FIFO holds one word 0x5A; fifo_empty rises the cycle after the read -> exactly one 0x5A delivered and no further fifo_r_en.
6. Counter wrap: CNT_WIDTH=4, 17 handshakes -> rd_count reads 15 then 0 then 1.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared widths, default read latency and state type for the FIFO read stage
package fifo_rd_stream_pkg;

    localparam int PKG_FIFO_WIDTH = 32;
    localparam int PKG_RD_LAT     = 1;

    typedef enum logic {
        STREAM = 1'b0,
        FLUSH  = 1'b1
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// rtl/fifo_rd_stream_skid_buf.sv - circular skid buffer holding captured FIFO words
module fifo_rd_stream_skid_buf #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [OCC_W-1:0] o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - rclk-domain FIFO consumer: credit-gated reads into a skid buffer feeding a valid/ready stream
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int FIFO_WIDTH = PKG_FIFO_WIDTH,
    parameter int SKID_DEPTH = 2,
    parameter int RD_LAT     = PKG_RD_LAT,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_r_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count
);

    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

    rd_state_e             r_state;
    rd_state_e             w_state_nxt;
    logic [RD_LAT-1:0]     r_inflight;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [OCC_W-1:0]      w_occ;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [31:0]           w_demand;

    assign m_valid = (w_occ != '0);
    assign w_pop   = m_valid && m_ready && (r_state == STREAM) && !flush;

    // Words already owed to the buffer (stored plus in flight) after this cycle's pop.
    assign w_demand = 32'(w_occ) + 32'($countones(r_inflight)) - {31'd0, w_pop};

    assign w_issue   = rrst_n && (r_state == STREAM) && !flush && !fifo_empty
                       && (w_demand < 32'(SKID_DEPTH));
    assign fifo_r_en = w_issue;

    // Returning data is only kept while streaming; a flush cycle or FLUSH state drops it.
    assign w_push = r_inflight[RD_LAT-1] && (r_state == STREAM) && !flush;

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_inflight <= '0;
            r_state    <= STREAM;
            r_count    <= '0;
        end else begin
            r_inflight <= (r_inflight << 1) | RD_LAT'(w_issue);
            r_state    <= w_state_nxt;
            if (w_pop) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            STREAM: if (flush) w_state_nxt = FLUSH;
            FLUSH:  if (!flush && (r_inflight == '0)) w_state_nxt = STREAM;
            default: w_state_nxt = STREAM;
        endcase
    end

    fifo_rd_stream_skid_buf #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .i_clear     (flush),
        .i_push      (w_push),
        .i_push_data (fifo_data_out),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (m_data)
    );

    assign busy     = (r_state == FLUSH);
    assign rd_count = r_count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - randomized bench for fifo_rd_stream against a queue-based model
module tb_fifo_rd_stream;

    localparam int W  = 32;
    localparam int SD = 2;
    localparam int RL = 1;
    localparam int CW = 4;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          fifo_empty;
    logic [W-1:0]  fifo_data_out;
    logic          fifo_r_en;
    logic          flush;
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic          m_ready;
    logic          busy;
    logic [CW-1:0] rd_count;

    fifo_rd_stream #(
        .FIFO_WIDTH (W),
        .SKID_DEPTH (SD),
        .RD_LAT     (RL),
        .CNT_WIDTH  (CW)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_r_en     (fifo_r_en),
        .flush         (flush),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .busy          (busy),
        .rd_count      (rd_count)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [W-1:0] data;
        int           rdy;
    } ent_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  fifo_q[$];
    logic [W-1:0]  pipe[RL];
    logic [W-1:0]  got_q[$];
    ent_t          exp_q[$];
    int            now      = 0;
    int            last_rd  = -100;
    bit            busy_m   = 0;
    bit            take     = 0;
    logic [CW-1:0] cnt_m    = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    // FIFO environment: pops on a sampled read, returns data RL cycles later.
    task automatic env_step();
        for (int i = RL - 1; i > 0; i--) pipe[i] = pipe[i-1];
        if (take && fifo_q.size() > 0) pipe[0] = fifo_q.pop_front();
        else                           pipe[0] = $urandom;
        fifo_data_out = pipe[RL-1];
        fifo_empty    = (fifo_q.size() == 0);
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
        env_step();
    endtask

    task automatic load(input logic [W-1:0] d);
        fifo_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    // Reference: every word read is owed downstream RL+1 cycles later unless a flush drops it.
    always @(negedge rclk) begin
        logic exp_v;
        logic exp_ren;
        logic pop;
        int   pend;
        ent_t e;
        if (!rrst_n) begin
            exp_q.delete();
            busy_m  = 0;
            cnt_m   = '0;
            take    = 0;
            last_rd = -100;
        end else begin
            exp_v   = (exp_q.size() > 0) && (exp_q[0].rdy <= now);
            pop     = exp_v && m_ready && !flush;
            pend    = exp_q.size() - (pop ? 1 : 0);
            exp_ren = !busy_m && !flush && !fifo_empty && (pend < SD);
            chk("fifo_r_en", fifo_r_en, exp_ren);
            chk("m_valid", m_valid, exp_v);
            if (exp_v) chk("m_data", m_data, exp_q[0].data);
            chk("busy", busy, busy_m);
            chk("rd_count", rd_count, cnt_m);
            if (flush) begin
                exp_q.delete();
                busy_m = 1;
            end else begin
                if (busy_m && now > last_rd + RL) busy_m = 0;
                if (pop) begin
                    got_q.push_back(m_data);
                    void'(exp_q.pop_front());
                    cnt_m = cnt_m + 1'b1;
                end
            end
            take = fifo_r_en;
            if (fifo_r_en && fifo_q.size() > 0) begin
                e.data = fifo_q[0];
                e.rdy  = now + RL + 1;
                exp_q.push_back(e);
                last_rd = now;
            end
        end
        now++;
    end

    initial begin
        int n0;
        rrst_n        = 1'b0;
        flush         = 1'b0;
        m_ready       = 1'b0;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        for (int i = 0; i < RL; i++) pipe[i] = '0;

        load(32'h11); load(32'h22); load(32'h33);
        tick(); tick();
        @(negedge rclk);
        chk("rst_r_en", fifo_r_en, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_rd_count", rd_count, '0);
        chk("rst_busy", busy, 1'b0);
        tick();
        rrst_n  = 1'b1;
        @(negedge rclk);
        chk("rel_first_r_en", fifo_r_en, 1'b1);
        tick();
        m_ready = 1'b1;
        repeat (8) tick();

        n0 = got_q.size();
        for (int i = 1; i <= 8; i++) load(W'(i));
        repeat (14) tick();
        chk("stream_words", got_q.size() - n0, 8);
        for (int i = 0; i < 8 && n0 + i < got_q.size(); i++) chk("stream_order", got_q[n0+i], W'(i + 1));

        n0 = got_q.size();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(W'(32'hA0 + i));
        repeat (6) tick();
        @(negedge rclk);
        chk("bp_hold_valid", m_valid, 1'b1);
        chk("bp_hold_data", m_data, 32'hA0);
        chk("bp_fifo_left", fifo_q.size(), 2);
        m_ready = 1'b1;
        repeat (10) tick();
        chk("bp_words", got_q.size() - n0, 4);
        for (int i = 0; i < 4 && n0 + i < got_q.size(); i++) chk("bp_order", got_q[n0+i], W'(32'hA0 + i));

        n0 = got_q.size();
        load(32'hB4);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        load(32'hB5);
        @(negedge rclk);
        chk("flush_busy", busy, 1'b1);
        chk("flush_m_valid", m_valid, 1'b0);
        repeat (8) tick();
        chk("flush_words", got_q.size() - n0, 1);
        if (got_q.size() > n0) chk("flush_first", got_q[n0], 32'hB5);

        n0 = got_q.size();
        load(32'h5A);
        repeat (8) tick();
        chk("empty_words", got_q.size() - n0, 1);
        if (got_q.size() > n0) chk("empty_word", got_q[n0], 32'h5A);

        for (int c = 0; c < 600; c++) begin
            tick();
            m_ready = ($urandom % 4) != 0;
            if (($urandom % 3) == 0) load($urandom);
            flush  = ($urandom % 30) == 0;
            rrst_n = ($urandom % 200) != 0;
        end
        tick();
        flush   = 1'b0;
        rrst_n  = 1'b1;
        m_ready = 1'b1;
        repeat (40) tick();
        chk("drain_fifo", fifo_q.size(), 0);
        chk("drain_valid", m_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
